// File: rtl/accum_dump_decimator.sv
// -----------------------------------------------------------------------------
// accum_dump_decimator
//
// Boxcar integrate-and-dump decimator for signed AXI-stream samples. It sums
// 2^R accepted samples, then emits one averaged sample: the block sum
// arithmetically shifted right by R. R can be changed at run time with the
// sel strobe. This block sits after the sum/delay comb stage, and the pair
// forms a cheap moving-average/decimate chain in front of the DDC output.
//
// Optional feature macro: ACCUM_DUMP_ROUND_EN
//   defined   : add 2^(R-1) before the shift (round half up toward +inf)
//   undefined : plain arithmetic-shift truncation (toward -inf)
// Handshake and latency are the same in both builds.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset (R <= DEFAULT_LOG2)
//   clear      in   synchronous flush of accumulator/count/output, R is kept
//   i_tdata    in   [WIDTH-1:0] signed input sample
//   i_tvalid   in   input valid
//   i_tready   out  input ready (= ~o_tvalid | o_tready)
//   o_tdata    out  [WIDTH-1:0] signed decimated output
//   o_tvalid   out  output valid
//   o_tready   in   downstream ready
//   sel_data   in   [RATE_W-1:0] new R, clamped to MAX_LOG2
//   sel_valid  in   strobe that loads sel_data into R and restarts the block
// -----------------------------------------------------------------------------
module accum_dump_decimator #(
  parameter int WIDTH        = 16,
  parameter int MAX_LOG2     = 7,
  parameter int RATE_W       = 3,
  parameter int DEFAULT_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [WIDTH-1:0]  o_tdata,
  output logic              o_tvalid,
  input  logic              o_tready,
  input  logic [RATE_W-1:0] sel_data,
  input  logic              sel_valid
);

  // The accumulator has MAX_LOG2 guard bits, so a full block of 2^MAX_LOG2
  // extreme samples cannot overflow it.
  localparam int ACC_W = WIDTH + MAX_LOG2;
  // The sample counter runs from 0 to 2^R-1, which needs MAX_LOG2 bits.
  localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  // The block length limit 2^R-1 is formed one bit wider so that 2^R
  // never truncates before the subtraction.
  localparam int LIM_W = CNT_W + 1;

  logic [RATE_W-1:0]       rate_log2;
  logic signed [ACC_W-1:0] accum;
  logic [CNT_W-1:0]        count;

  logic                    accept;
  logic                    is_last;
  logic [LIM_W-1:0]        count_limit;
  logic [RATE_W-1:0]       sel_clamped;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] total;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] rounded;
  logic [WIDTH-1:0]        dump_data;

  // There is one output register and no skid buffer. A new sample may enter
  // only when that register is empty or is being drained in this cycle.
  assign i_tready = ~o_tvalid | o_tready;
  assign accept   = i_tvalid & i_tready;

  // NOTE: every signal written in always_comb gets a default value first.
  // That way no path leaves it unassigned, so no latch is inferred.
  always_comb begin
    sel_clamped = sel_data;
    if (sel_data > RATE_W'(MAX_LOG2)) begin
      sel_clamped = RATE_W'(MAX_LOG2);
    end

    count_limit = (LIM_W'(1) << rate_log2) - LIM_W'(1);
    is_last     = ({1'b0, count} == count_limit);

    sample_ext  = {{MAX_LOG2{i_tdata[WIDTH-1]}}, i_tdata};
    total       = accum + sample_ext;

    rnd = '0;
`ifdef ACCUM_DUMP_ROUND_EN
    if (rate_log2 != '0) begin
      rnd = ACC_W'(1) << (rate_log2 - RATE_W'(1));
    end
`endif
    rounded = total + rnd;

    // Rounding up the max positive average lands exactly on
    // 2^(WIDTH-1)-1 after the floor shift. Truncating to WIDTH bits
    // therefore never wraps, and no saturation logic is needed.
    dump_data = WIDTH'(rounded >>> rate_log2);
  end

  // NOTE: sequential state uses non-blocking assignments. Every register
  // then updates from the values before the clock edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_log2 <= RATE_W'(DEFAULT_LOG2);
      accum     <= '0;
      count     <= '0;
      o_tvalid  <= 1'b0;
      o_tdata   <= '0;
    end else if (clear) begin
      // A flush drops any pending output but keeps the selected rate.
      accum     <= '0;
      count     <= '0;
      o_tvalid  <= 1'b0;
      o_tdata   <= '0;
    end else begin
      // The output is drained first. A dump in the same cycle below
      // overrides this, so a back-to-back dump keeps o_tvalid high.
      if (o_tvalid && o_tready) begin
        o_tvalid <= 1'b0;
      end

      if (sel_valid) begin
        // A rate change restarts the block. A sample accepted in the same
        // cycle is discarded, and a pending output is left untouched.
        rate_log2 <= sel_clamped;
        accum     <= '0;
        count     <= '0;
      end else if (accept) begin
        if (is_last) begin
          o_tdata  <= dump_data;
          o_tvalid <= 1'b1;
          accum    <= '0;
          count    <= '0;
        end else begin
          accum    <= total;
          count    <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/accum_dump_decimator.md
Name: accum_dump_decimator

Overview:
- Downstream stage of the sum/delay (comb) filter: boxcar integrate-and-dump decimator on signed AXI-stream samples.
- Accumulates 2^R accepted input samples, then emits one averaged sample: the accumulated sum arithmetically shifted right by R.
- R is runtime-selectable via a sel strobe.
- Together with the upstream comb, forms a low-cost moving-average/decimate chain ahead of the DDC output.

Parameters:
- WIDTH, 16, sample width, signed two's complement, input and output.
- MAX_LOG2, 7, largest supported log2 decimation; sets accumulator width to WIDTH+MAX_LOG2.
- RATE_W, 3, width of sel_data; must satisfy 2^RATE_W > MAX_LOG2.
- DEFAULT_LOG2, 2, R loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous, active-high flush; R is preserved
- i_tdata  in  WIDTH  signed input sample
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  WIDTH  signed decimated output
- o_tvalid  out  1  output valid
- o_tready  in  1  downstream ready
- sel_data  in  RATE_W  new R (log2 decimation)
- sel_valid  in  1  strobe; loads sel_data into R

Behaviour:
- Reset (reset high at posedge):
  - R=DEFAULT_LOG2, accum=0, count=0, o_tvalid=0, o_tdata=0.
  - i_tready=1 from the cycle after reset.
- clear: same as reset except R is kept. A pending output is dropped (o_tvalid=0).
- R loading:
  - sel_valid loads min(sel_data, MAX_LOG2) into R.
  - It also zeroes accum and count, discarding the partial block.
  - It does not drop a pending output.
  - sel_valid in the same cycle as an input accept: the sample is discarded and the new R takes effect for the next sample.
- Input handshake:
  - i_tready = ~o_tvalid | o_tready (single output register, no skid).
  - A sample is accepted when i_tvalid & i_tready.
- Accumulation:
  - Accumulator is signed, WIDTH+MAX_LOG2 bits. Inputs are sign-extended. Overflow is impossible by construction.
  - Each accepted sample with count < 2^R-1: accum <= accum + x, count <= count+1.
- Dump:
  - Accepted sample with count == 2^R-1: total = accum + x.
  - o_tdata <= (total + rnd) >>> R, then truncated to WIDTH. rnd is defined under Optional Feature.
  - Same cycle: o_tvalid <= 1, accum <= 0, count <= 0.
- Latency: o_tvalid asserts 1 cycle after the last sample of the block is accepted.
- Output handshake:
  - o_tvalid & o_tready clears o_tvalid, unless a new dump occurs in the same cycle; then o_tvalid stays 1 with the new data.
  - o_tdata holds stable while o_tvalid & ~o_tready.
- R=0 (pass-through):
  - Every accepted sample dumps; o_tdata = x with one cycle of latency.
  - Full throughput of one sample per cycle when o_tready=1.
- Back-pressure: while o_tvalid & ~o_tready, i_tready=0. No samples are lost; accum and count are frozen.
- Output range:
  - The average of WIDTH-bit values fits in WIDTH bits, except round-up of the max positive value.
  - That case is floored back to max positive ((2^(WIDTH-1)-1)·N + N/2) >> R = 2^(WIDTH-1)-1. No saturation logic is needed.

Optional Feature:
- Macro: ACCUM_DUMP_ROUND_EN.
- Defined: rnd = 2^(R-1) for R>0 and 0 for R=0 (round half up toward +inf).
- Undefined: rnd = 0 (pure arithmetic-shift truncation toward -inf); the rounding adder is removed.
- Handshake and latency are identical in both builds.

Test Plan:
- Reset, then R=2, stream 100,200,300,401 with o_tready=1 -> one output 250; o_tvalid high exactly 1 cycle after 401 is accepted. ROUND_EN: (1001+2)>>2=250; no ROUND_EN: 250.
- R=1, inputs -3,-4 -> ROUND_EN: -3 ((-7+1)>>>1); no ROUND_EN: -4.
- R=7, 128 samples of 32767 -> 32767; 128 samples of -32768 -> -32768; no wrap.
- R=0, 10 back-to-back samples 1..10 with o_tready=1 -> outputs 1..10, one per cycle, i_tready stays 1.
- R=2, hold o_tready=0 after first dump, keep i_tvalid=1 -> i_tready=0, o_tdata frozen, zero inputs consumed; release o_tready -> next block sums correctly.
- Mid-block (2 of 4 samples), pulse sel_valid with sel_data=1, then send 6,8 -> output 7; partial block discarded. Repeat with clear mid-block -> no output, and R is unchanged.
